// File: rtl/bram_sdram_responder.sv
// bram_sdram_responder
//   Block-RAM backed slave that answers a simple SDRAM-style request/ack
//   handshake. Each request is accepted with a one-cycle ack after an
//   optional wait period. Writes land at the end of the ack cycle under
//   byte-lane control. Reads return through a fixed-latency pipeline.
//
// State table:
//   S_IDLE | waiting for sdram_request; loads the wait counter when it is seen
//   S_WAIT | counting down ACK_DELAY cycles; request dropping here aborts
//   S_ACK  | acceptance cycle; write/read performed with the inputs of this cycle
//
// Ports:
//   clock              single clock, all logic on posedge
//   reset              synchronous, active-high
//   sdram_request      initiator holds high until it samples ack
//   sdram_addr[25:0]   byte address; word index = addr[25:2] mod MEM_WORDS
//   sdram_write        1 = write, 0 = read
//   sdram_byte_enable  write byte lanes, bit n -> wdata[8n+7:8n]
//   sdram_wdata[31:0]  write data
//   sdram_ack          one-cycle acceptance pulse (registered)
//   sdram_rdata[31:0]  read data, forced to 0 when rdvalid is low
//   sdram_rdvalid      one-cycle read-data pulse, READ_LATENCY after ack
//   protocol_error     sticky: request dropped in WAIT or ACK
module bram_sdram_responder #(
  parameter int MEM_WORDS    = 16384,
  parameter int ACK_DELAY    = 0,
  parameter int READ_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sdram_request,
  input  logic [25:0] sdram_addr,
  input  logic        sdram_write,
  input  logic [3:0]  sdram_byte_enable,
  input  logic [31:0] sdram_wdata,
  output logic        sdram_ack,
  output logic [31:0] sdram_rdata,
  output logic        sdram_rdvalid,
  output logic        protocol_error
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [3:0]  wait_cnt, wait_cnt_next;
  logic        error_next;
  logic        do_write, do_read;
  logic [IDX_W-1:0] idx;

  logic [31:0] mem [MEM_WORDS];
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [31:0]             pipe_data [READ_LATENCY];

  // Low address bits and bits above the memory size are deliberately ignored
  // (sub-word offset and address wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{sdram_addr[1:0], sdram_addr >> (IDX_W + 2)};

  assign idx = sdram_addr[IDX_W+1:2];

  // Request fields are used live in the ACK cycle, never latched.
  // A request that vanishes in the ACK cycle suppresses the memory action.
  assign do_write = (state == S_ACK) && sdram_request && sdram_write;
  assign do_read  = (state == S_ACK) && sdram_request && !sdram_write;

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    error_next    = protocol_error;
    case (state)
      S_IDLE: begin
        if (sdram_request) begin
          wait_cnt_next = 4'(ACK_DELAY);
          state_next    = (ACK_DELAY > 0) ? S_WAIT : S_ACK;
        end
      end
      S_WAIT: begin
        if (!sdram_request) begin
          state_next    = S_IDLE;
          wait_cnt_next = '0;
          error_next    = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state_next = S_ACK;
        end
      end
      S_ACK: begin
        state_next = S_IDLE;
        if (!sdram_request) error_next = 1'b1;
      end
      default: begin
        state_next    = S_IDLE;
        wait_cnt_next = '0;
      end
    endcase
  end

  // sdram_ack is a flop that mirrors "next state is ACK", so it is high
  // exactly while the FSM sits in S_ACK.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      wait_cnt       <= '0;
      sdram_ack      <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      state          <= state_next;
      wait_cnt       <= wait_cnt_next;
      sdram_ack      <= (state_next == S_ACK);
      protocol_error <= error_next;
    end
  end

  // Memory and read-return pipeline. Memory is never cleared by reset; a
  // write that coincides with reset is dropped. Stage 0 captures the word
  // as it stands before the edge ending the ACK cycle; later stages shift
  // unconditionally and only the valid bits carry meaning.
  always_ff @(posedge clock) begin
    if (do_write && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (sdram_byte_enable[b]) mem[idx][8*b +: 8] <= sdram_wdata[8*b +: 8];
      end
    end
    pipe_data[0] <= mem[idx];
    for (int i = 1; i < READ_LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
    if (reset) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= do_read;
      for (int i = 1; i < READ_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
    end
  end

  assign sdram_rdvalid = pipe_valid[READ_LATENCY-1];
  assign sdram_rdata   = sdram_rdvalid ? pipe_data[READ_LATENCY-1] : 32'h0;

endmodule

// File: tb/tb_bram_sdram_responder.sv
// Directed bench for bram_sdram_responder. Three instances share clock and
// reset: u0 defaults, u1 READ_LATENCY=4, u2 ACK_DELAY=3.
module tb_bram_sdram_responder;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [2:0]  req, wr, ack, rv, perr;
  logic [25:0] addr [3];
  logic [3:0]  be   [3];
  logic [31:0] wd   [3];
  logic [31:0] rdata[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bram_sdram_responder #(
      .MEM_WORDS   (16384),
      .ACK_DELAY   ((g == 2) ? 3 : 0),
      .READ_LATENCY((g == 1) ? 4 : 2)
    ) dut (
      .clock            (clock),
      .reset            (reset),
      .sdram_request    (req[g]),
      .sdram_addr       (addr[g]),
      .sdram_write      (wr[g]),
      .sdram_byte_enable(be[g]),
      .sdram_wdata      (wd[g]),
      .sdram_ack        (ack[g]),
      .sdram_rdata      (rdata[g]),
      .sdram_rdvalid    (rv[g]),
      .protocol_error   (perr[g])
    );
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One complete transaction on instance d; checks ack latency, ack width,
  // and for reads the rdvalid latency and returned data.
  task automatic xact(input int d, input bit w, input logic [25:0] a,
                      input logic [3:0] b, input logic [31:0] data,
                      input int exp_ack, input logic [31:0] exp_rd, input string nm);
    int n;
    bit got;
    int lat;
    logic [31:0] seen;
    lat = (d == 1) ? 4 : 2;
    req[d] = 1'b1; wr[d] = w; addr[d] = a; be[d] = b; wd[d] = data;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      step();
      n++;
      got = ack[d];
    end
    chk({nm, " ack_latency"}, 32'(n), 32'(exp_ack));
    step();
    req[d] = 1'b0;
    chk({nm, " ack_width"}, {31'h0, ack[d]}, 32'h0);
    if (!w) begin
      n = 1; got = rv[d]; seen = rdata[d];
      while (!got && n < 20) begin
        step();
        n++;
        got = rv[d];
        seen = rdata[d];
      end
      chk({nm, " rdvalid_latency"}, 32'(n), 32'(lat));
      chk({nm, " rdata"}, seen, exp_rd);
    end else begin
      step();
    end
  endtask

  typedef struct {
    bit          w;
    logic [25:0] a;
    logic [3:0]  b;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [10];

  initial begin
    int n;
    int bad;
    bit exp_v;
    logic [31:0] exp_d;

    vt[0] = '{1'b1, 26'h100,   4'b1111, 32'hDEADBEEF, 32'h0};
    vt[1] = '{1'b0, 26'h100,   4'b0000, 32'h0,        32'hDEADBEEF};
    vt[2] = '{1'b1, 26'h100,   4'b0100, 32'h00AA0000, 32'h0};
    vt[3] = '{1'b0, 26'h100,   4'b0000, 32'h0,        32'hDEAABEEF};
    vt[4] = '{1'b1, 26'h10000, 4'b1111, 32'h5,        32'h0};
    vt[5] = '{1'b0, 26'h0,     4'b0000, 32'h0,        32'h5};
    vt[6] = '{1'b1, 26'h200,   4'b1111, 32'h12345678, 32'h0};
    vt[7] = '{1'b1, 26'h200,   4'b0000, 32'hFFFFFFFF, 32'h0};
    vt[8] = '{1'b1, 26'h201,   4'b1001, 32'hAABBCCDD, 32'h0};
    vt[9] = '{1'b0, 26'h203,   4'b0000, 32'h0,        32'hAA3456DD};

    reset = 1'b1;
    req = '0; wr = '0;
    for (int i = 0; i < 3; i++) begin
      addr[i] = '0; be[i] = '0; wd[i] = '0;
    end
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset ack u%0d", i),   {31'h0, ack[i]},  32'h0);
      chk($sformatf("reset rv u%0d", i),    {31'h0, rv[i]},   32'h0);
      chk($sformatf("reset rdata u%0d", i), rdata[i],         32'h0);
      chk($sformatf("reset perr u%0d", i),  {31'h0, perr[i]}, 32'h0);
    end

    // Table-driven transactions on the default instance.
    for (int i = 0; i < 10; i++)
      xact(0, vt[i].w, vt[i].a, vt[i].b, vt[i].data, 1, vt[i].exp, $sformatf("vec%0d", i));
    chk("u0 perr after table", {31'h0, perr[0]}, 32'h0);

    // Pipelined reads, READ_LATENCY=4: request held across two transactions.
    xact(1, 1'b1, 26'h0, 4'hF, 32'h1, 1, 32'h0, "pipe_wr0");
    xact(1, 1'b1, 26'h4, 4'hF, 32'h2, 1, 32'h0, "pipe_wr1");
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 26'h0;
    n = 0;
    while (!ack[1] && n < 40) begin
      step();
      n++;
    end
    chk("pipe first ack latency", 32'(n), 32'd1);
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 1) addr[1] = 26'h4;
      if (k == 3) req[1] = 1'b0;
      exp_v = (k == 4) || (k == 6);
      exp_d = (k == 4) ? 32'h1 : (k == 6) ? 32'h2 : 32'h0;
      chk($sformatf("pipe ack k=%0d", k),   {31'h0, ack[1]}, {31'h0, k == 2});
      chk($sformatf("pipe rv k=%0d", k),    {31'h0, rv[1]},  {31'h0, exp_v});
      chk($sformatf("pipe rdata k=%0d", k), rdata[1],        exp_d);
    end

    // ACK_DELAY=3: held request, then a drop in WAIT.
    xact(2, 1'b1, 26'h40, 4'hF, 32'h77, 4, 32'h0,  "d3_wr");
    xact(2, 1'b0, 26'h40, 4'h0, 32'h0,  4, 32'h77, "d3_rd");
    chk("d3 perr clean", {31'h0, perr[2]}, 32'h0);
    req[2] = 1'b1; wr[2] = 1'b0; addr[2] = 26'h40;
    step(); step();
    req[2] = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (ack[2] || rv[2]) bad++;
    end
    chk("d3 abort no ack/rdvalid", 32'(bad), 32'd0);
    chk("d3 perr set", {31'h0, perr[2]}, 32'h1);
    step(); step(); step();
    chk("d3 perr sticky", {31'h0, perr[2]}, 32'h1);

    // Reset one cycle after a read ack drops the in-flight read.
    xact(0, 1'b1, 26'h300, 4'hF, 32'hCAFEF00D, 1, 32'h0, "rst_wr");
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 26'h300;
    n = 0;
    while (!ack[0] && n < 40) begin
      step();
      n++;
    end
    chk("rst read ack latency", 32'(n), 32'd1);
    step();
    req[0] = 1'b0;
    reset = 1'b1;
    step();
    chk("rst ack",   {31'h0, ack[0]},  32'h0);
    chk("rst rv",    {31'h0, rv[0]},   32'h0);
    chk("rst rdata", rdata[0],         32'h0);
    chk("rst perr u2 cleared", {31'h0, perr[2]}, 32'h0);
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      if (rv[0]) bad++;
      step();
    end
    chk("rst no stale rdvalid", 32'(bad), 32'd0);
    xact(0, 1'b0, 26'h300, 4'h0, 32'h0, 1, 32'hCAFEF00D, "rst_rd");
    xact(0, 1'b0, 26'h100, 4'h0, 32'h0, 1, 32'hDEAABEEF, "rst_rd_old");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_sdram_responder.md
BRAM_SDRAM_RESPONDER -- requirements
Module: bram_sdram_responder

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- MEM_WORDS, 16384: 32-bit words of backing store; power of two.
- ACK_DELAY, 0: extra wait cycles before ack; range 0..15.
- READ_LATENCY, 2: cycles from the ack cycle to rdvalid; range 1..8.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock  in  1: single clock; all logic on posedge.
- reset  in  1: synchronous, active-high.
- sdram_request  in  1: initiator holds high until it samples ack.
- sdram_addr  in  26: byte address.
- sdram_write  in  1: 1 = write, 0 = read.
- sdram_byte_enable  in  4: write byte lanes; bit n selects wdata[8n+7:8n].
- sdram_wdata  in  32: write data.
- sdram_ack  out  1: one-cycle acceptance pulse.
- sdram_rdata  out  32: read data; 0 when rdvalid is low.
- sdram_rdvalid  out  1: one-cycle read-data pulse.
- protocol_error  out  1: sticky protocol-violation flag.

Function
REQ-003 Word index SHALL be sdram_addr[25:2] modulo MEM_WORDS; addr[1:0] ignored; out-of-range addresses wrap with no error.
REQ-004 The FSM SHALL have exactly three states:
- IDLE: request sampled high -> load wait counter with ACK_DELAY; go to WAIT if ACK_DELAY>0, else ACK.
- WAIT: decrement counter each cycle; go to ACK when it reaches 0.
- ACK: sdram_ack=1 for exactly this cycle; always return to IDLE next cycle.
REQ-005 sdram_ack SHALL be a registered output that is high only in state ACK.
REQ-006 Request field inputs SHALL NOT be latched; the ACK cycle SHALL use the values present on the inputs during that cycle.
REQ-007 A write SHALL update only the enabled byte lanes at the clock edge ending the ACK cycle. byte_enable=0000 still acks, with memory unchanged.
REQ-008 A read SHALL address memory in the ACK cycle. sdram_rdvalid SHALL pulse exactly READ_LATENCY cycles after the ACK cycle, with the word value as of the end of the ACK cycle.
REQ-009 The rdvalid/rdata return path SHALL be a READ_LATENCY-deep pipeline, so every read still in flight is delivered in order.
REQ-010 A write acked in the same cycle that an earlier read returns rdvalid SHALL NOT alter that returned data.
REQ-011 Sequential access SHALL be read-after-write coherent: a read acked after a write acks returns the written bytes.
REQ-012 Throughput SHALL be one transaction per ACK_DELAY+2 cycles. A request held high, or re-raised in the cycle after ACK, SHALL be sampled in IDLE as a new transaction.
REQ-013 If request is low in WAIT, or low in the ACK cycle:
- the transaction SHALL be aborted: no ack, no write, no rdvalid;
- the FSM SHALL return to IDLE;
- protocol_error SHALL be set.
REQ-014 protocol_error SHALL remain set until reset.
REQ-015 sdram_rdata SHALL be driven to 32'h0 in every cycle that sdram_rdvalid is 0.

Reset
REQ-016 While reset is high at a clock edge, these SHALL be cleared at that edge:
- FSM to IDLE, wait counter to 0;
- sdram_ack=0, sdram_rdvalid=0, sdram_rdata=0, protocol_error=0;
- the read pipeline, discarding in-flight reads.
REQ-017 Memory contents SHALL NOT be altered by reset.
REQ-018 A request pending in WAIT or ACK when reset asserts SHALL be dropped without a write. The initiator's reset is responsible for clearing its own request.
REQ-019 The first request SHALL be sampled at the first edge after reset deasserts.

Verification
REQ-020 The bench SHALL cover these directed scenarios (defaults unless stated):
- Write then read: write 0x100 = 32'hDEADBEEF, BE=1111; read 0x100 -> ack 1 cycle after request sampled; rdvalid 2 cycles after ack; rdata = DEADBEEF.
- Byte lanes: write 0x100 BE=0100, wdata=32'h00AA0000 over DEADBEEF; read -> 32'hDEAABEEF.
- Pipelined reads: READ_LATENCY=4, two reads back-to-back to 0x0 and 0x4 holding 1 and 2 -> rdvalid pulses 2 cycles apart, data 1 then 2, rdata=0 between pulses.
- Wrap: MEM_WORDS=16384; write 0x10000 = 5; read 0x0 -> 5.
- ACK_DELAY=3: request held -> ack in 4th cycle after sampling; drop request in WAIT -> no ack, protocol_error=1 until reset.
- Reset mid-read: assert reset 1 cycle after a read ack -> rdvalid never pulses; all outputs 0 after the reset edge; the next read after reset returns the prior memory value.
